// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_driver
// Brief    : Three-channel PWM LED driver with a one-entry duty buffer that is
//            applied only at a PWM period boundary.
// Revision : 1.0
// ============================================================================
module rgb_pwm_driver #(
    parameter int W        = 8,
    parameter int PRESCALE = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         duty_valid,
    output logic         duty_ready,
    input  logic [W-1:0] duty_r,
    input  logic [W-1:0] duty_g,
    input  logic [W-1:0] duty_b,
    output logic         led_red,
    output logic         led_green,
    output logic         led_blue,
    output logic         period_start
);

    localparam int              c_PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(PRESCALE - 1);
    localparam logic [W-1:0]    c_CNT_MAX = '1;

    logic [c_PW-1:0] r_pre_cnt;
    logic [W-1:0]    r_pwm_cnt;
    logic [W-1:0]    r_act_r, r_act_g, r_act_b;
    logic [W-1:0]    r_pend_r, r_pend_g, r_pend_b;
    logic            r_pend_full;
    logic            r_led_red, r_led_green, r_led_blue;
    logic            r_period_start;

    logic            w_tick;
    logic            w_wrap;
    logic            w_apply;
    logic            w_accept;
    logic [W-1:0]    w_pwm_nxt;
    logic [W-1:0]    w_act_r_nxt, w_act_g_nxt, w_act_b_nxt;

    assign w_tick   = (r_pre_cnt == c_PRE_MAX);
    assign w_wrap   = w_tick && (r_pwm_cnt == c_CNT_MAX);
    assign w_apply  = w_wrap && r_pend_full;
    assign w_accept = duty_valid && duty_ready;

    // LEDs compare against next-cycle counter/duty so a freshly applied duty
    // shows up in the same cycle as period_start.
    assign w_pwm_nxt   = w_tick  ? r_pwm_cnt + W'(1) : r_pwm_cnt;
    assign w_act_r_nxt = w_apply ? r_pend_r : r_act_r;
    assign w_act_g_nxt = w_apply ? r_pend_g : r_act_g;
    assign w_act_b_nxt = w_apply ? r_pend_b : r_act_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_act_r        <= '0;
            r_act_g        <= '0;
            r_act_b        <= '0;
            r_pend_r       <= '0;
            r_pend_g       <= '0;
            r_pend_b       <= '0;
            r_pend_full    <= 1'b0;
            r_led_red      <= 1'b0;
            r_led_green    <= 1'b0;
            r_led_blue     <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + c_PW'(1);
            r_pwm_cnt <= w_pwm_nxt;
            r_act_r   <= w_act_r_nxt;
            r_act_g   <= w_act_g_nxt;
            r_act_b   <= w_act_b_nxt;

            // Accept needs an empty slot and apply needs a full one, so the
            // two never coincide and an accepted value always waits a wrap.
            if (w_accept) begin
                r_pend_r    <= duty_r;
                r_pend_g    <= duty_g;
                r_pend_b    <= duty_b;
                r_pend_full <= 1'b1;
            end else if (w_apply) begin
                r_pend_full <= 1'b0;
            end

            r_led_red      <= (w_pwm_nxt < w_act_r_nxt);
            r_led_green    <= (w_pwm_nxt < w_act_g_nxt);
            r_led_blue     <= (w_pwm_nxt < w_act_b_nxt);
            r_period_start <= w_wrap;
        end
    end

    assign duty_ready   = !r_pend_full && !rst;
    assign led_red      = r_led_red;
    assign led_green    = r_led_green;
    assign led_blue     = r_led_blue;
    assign period_start = r_period_start;

endmodule
`default_nettype wire
